game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//  Top-level game-state sequencer. Sits upstream of the ghost movers and pacman mover.
//  Drives their start_game / game_over / counter inputs.
//  Consumes pacman and ghost positions to detect collisions, track lives, time
//  scatter/chase phases, and sequence READY -> PLAY -> DEATH/OVER/WIN.
// PARAMETERS
//  NUM_GHOSTS    4    ghosts compared for collision
//  LIVES_INIT    3    lives loaded on reset and on new game
//  SEC_FRAMES    60   frames per counter tick
//  MODE_PERIOD   20   counter wraps to 0 after MODE_PERIOD-1
//  READY_FRAMES  120  frames held in READY before play
//  DEATH_FRAMES  90   frames held in DEATH (death animation)
//  HIT_DIST      12   collision if |dx|<HIT_DIST and |dy|<HIT_DIST (pixels)
// PORTS
//  frame_clk   in   1              frame clock (one edge per video frame)
//  Reset       in   1              asynchronous, active-high
//  start_btn   in   1              level from keyboard decode; rising edge acts
//  pac_x       in   10             pacman top-left X
//  pac_y       in   10             pacman top-left Y
//  ghost_x     in   10*NUM_GHOSTS  packed ghost X, ghost i at [10i+9:10i]
//  ghost_y     in   10*NUM_GHOSTS  packed ghost Y
//  dots_left   in   8              remaining dots from pellet tracker
//  start_game  out  1              1 only in PLAY; movers freeze when 0
//  game_over   out  1              1 in OVER
//  win         out  1              1 in WIN
//  counter     out  5              phase-timer second count, 0..MODE_PERIOD-1
//  lives       out  2              remaining lives
//  respawn     out  1              one-frame pulse: movers reload start positions
//  state       out  3              current state_t, for HUD/debug
// BEHAVIOUR
//  Reset (async): state=IDLE; start_game=0; game_over=0; win=0; counter=0;
//   lives=LIVES_INIT; respawn=0; sub-frame and timer counters=0; btn_q=0.
//  All outputs registered. An event sampled at edge N is visible after edge N.
//  start_edge = start_btn & ~btn_q. btn_q is registered every frame.
//  IDLE:  start_edge -> READY, timer=READY_FRAMES-1, respawn pulse.
//  READY: timer decrements each frame. timer==0 -> PLAY, sub=0.
//  PLAY:  start_game=1. sub counts 0..SEC_FRAMES-1. At wrap, counter+1.
//   counter==MODE_PERIOD-1 at tick -> counter=0.
//   Priority, highest first, evaluated same frame:
//    dots_left==0 -> WIN. Win beats a simultaneous hit; lives unchanged.
//    any ghost hit -> DEATH, lives-1 (saturate at 0), timer=DEATH_FRAMES-1.
//   On a hit the counter freezes and does not tick that frame.
//  hit_i: |pac_x-gx_i|<HIT_DIST && |pac_y-gy_i|<HIT_DIST.
//   Use 10-bit unsigned absolute difference (larger minus smaller). No wrap terms.
//  DEATH: start_game=0, counter frozen, timer decrements.
//   At timer==0:
//    lives==0 -> OVER.
//    otherwise -> READY, counter=0, respawn=1 for that one frame,
//     timer=READY_FRAMES-1.
//  OVER / WIN: outputs held. start_edge -> READY, lives=LIVES_INIT, counter=0,
//   respawn pulse. start_btn held high from the previous game does not retrigger.
//  respawn is never high for more than one consecutive frame.
//  start_game, game_over, win are mutually exclusive.
//  Reset mid-operation (any state, including mid-timer): immediate return to reset values.
// STRUCTURE
//  game_pkg:
//   typedef enum logic[2:0] state_t {IDLE,READY,PLAY,DEATH,OVER,WIN};
//   SPRITE_SIZE=16; default HIT_DIST.
//  Sub-module sprite_hit (combinational abs-diff box compare, 1-bit hit).
//   Instantiated NUM_GHOSTS times via generate; outputs OR-reduced.
//  FSM: one always_ff plus one always_comb next-state block.
//   Timers 8-bit; sub 6-bit.
// TESTING
//  1 Reset, pulse start_btn -> respawn=1 one frame; start_game=1 exactly 120
//    frames later; state=PLAY.
//  2 PLAY 420 frames -> counter=7. At 1200 frames -> counter=0 (wrap at 19).
//  3 Ghost2 at (pac_x+5, pac_y+11) -> next frame state=DEATH, lives 3->2,
//    start_game=0, counter frozen. 90 frames later respawn pulse, READY, counter=0.
//  4 Three hits -> after the third DEATH, game_over=1 and lives=0. Held start_btn
//    has no effect; a new rising edge -> READY, lives=3, game_over=0.
//  5 dots_left=0 and ghost overlap in the same frame -> win=1, lives unchanged.
//    Ghost at dx=12 exactly -> no hit.
//  6 Reset asserted mid-DEATH (timer=40) -> all outputs at reset values before
//    the next frame_clk edge.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the game-state sequencer slice.
// Holds the state encoding, sprite geometry and the box-distance helper.
package game_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        DEATH = 3'd3,
        OVER  = 3'd4,
        WIN   = 3'd5
    } state_t;

    localparam int SPRITE_SIZE      = 16;
    localparam int HIT_DIST_DEFAULT = SPRITE_SIZE - 4;

    // Larger minus smaller keeps the result unsigned with no wrap terms.
    function automatic logic [9:0] absDiff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bus between the game sequencer and its neighbours: positions, dots and button in,
// play/over/win status, phase counter, lives and respawn pulse out.
interface game_ctrl_if #(parameter int NUM_GHOSTS = 4);
    import game_ctrl_pkg::*;

    logic                       start_btn;
    logic [9:0]                 pac_x;
    logic [9:0]                 pac_y;
    logic [10*NUM_GHOSTS-1:0]   ghost_x;
    logic [10*NUM_GHOSTS-1:0]   ghost_y;
    logic [7:0]                 dots_left;

    logic                       start_game;
    logic                       game_over;
    logic                       win;
    logic [4:0]                 counter;
    logic [1:0]                 lives;
    logic                       respawn;
    state_t                     state;

    modport master (
        output start_btn, pac_x, pac_y, ghost_x, ghost_y, dots_left,
        input  start_game, game_over, win, counter, lives, respawn, state
    );

    modport slave (
        input  start_btn, pac_x, pac_y, ghost_x, ghost_y, dots_left,
        output start_game, game_over, win, counter, lives, respawn, state
    );

endinterface

// File: rtl/game_ctrl_sprite_hit.sv
// Combinational overlap test between two sprites' top-left corners.
// A hit needs both axis distances strictly below HIT_DIST.
module game_ctrl_sprite_hit
    import game_ctrl_pkg::*;
#(
    parameter int HIT_DIST = HIT_DIST_DEFAULT
) (
    input  logic [9:0] i_ax,
    input  logic [9:0] i_ay,
    input  logic [9:0] i_bx,
    input  logic [9:0] i_by,
    output logic       o_hit
);

    localparam logic [9:0] HIT_LIM = 10'(HIT_DIST);

    logic [9:0] w_dx;
    logic [9:0] w_dy;

    assign w_dx  = absDiff(i_ax, i_bx);
    assign w_dy  = absDiff(i_ay, i_by);
    assign o_hit = (w_dx < HIT_LIM) && (w_dy < HIT_LIM);

endmodule

// File: rtl/game_ctrl.sv
// Top-level game sequencer: READY -> PLAY -> DEATH/OVER/WIN, with lives,
// scatter/chase phase timing and ghost collision detection.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int NUM_GHOSTS   = 4,
    parameter int LIVES_INIT   = 3,
    parameter int SEC_FRAMES   = 60,
    parameter int MODE_PERIOD  = 20,
    parameter int READY_FRAMES = 120,
    parameter int DEATH_FRAMES = 90,
    parameter int HIT_DIST     = HIT_DIST_DEFAULT
) (
    input  logic        frame_clk,
    input  logic        Reset,
    game_ctrl_if.slave  bus
);

    state_t          r_state;
    logic [7:0]      r_timer;
    logic [5:0]      r_sub;
    logic [4:0]      r_counter;
    logic [1:0]      r_lives;
    logic            r_respawn;
    logic            r_btnQ;

    state_t          w_nextState;
    logic [7:0]      w_nextTimer;
    logic [5:0]      w_nextSub;
    logic [4:0]      w_nextCounter;
    logic [1:0]      w_nextLives;
    logic            w_nextRespawn;
    logic            w_startEdge;
    logic [NUM_GHOSTS-1:0] w_ghostHit;
    logic            w_anyHit;

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_hit
        game_ctrl_sprite_hit #(.HIT_DIST(HIT_DIST)) u_hit (
            .i_ax  (bus.pac_x),
            .i_ay  (bus.pac_y),
            .i_bx  (bus.ghost_x[10*g +: 10]),
            .i_by  (bus.ghost_y[10*g +: 10]),
            .o_hit (w_ghostHit[g])
        );
    end

    assign w_anyHit    = |w_ghostHit;
    assign w_startEdge = bus.start_btn & ~r_btnQ;

    // Every piece of game state lives here so one async reset clears it all at once.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_sub     <= '0;
            r_counter <= '0;
            r_lives   <= 2'(LIVES_INIT);
            r_respawn <= 1'b0;
            r_btnQ    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_timer   <= w_nextTimer;
            r_sub     <= w_nextSub;
            r_counter <= w_nextCounter;
            r_lives   <= w_nextLives;
            r_respawn <= w_nextRespawn;
            r_btnQ    <= bus.start_btn;
        end
    end

    // Win outranks a same-frame hit; a hit freezes the phase counter for that frame.
    always_comb begin
        w_nextState   = r_state;
        w_nextTimer   = r_timer;
        w_nextSub     = r_sub;
        w_nextCounter = r_counter;
        w_nextLives   = r_lives;
        w_nextRespawn = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_startEdge) begin
                    w_nextState   = READY;
                    w_nextTimer   = 8'(READY_FRAMES - 1);
                    w_nextRespawn = 1'b1;
                end
            end
            READY: begin
                if (r_timer == 8'd0) begin
                    w_nextState = PLAY;
                    w_nextSub   = '0;
                end else begin
                    w_nextTimer = r_timer - 8'd1;
                end
            end
            PLAY: begin
                if (bus.dots_left == 8'd0) begin
                    w_nextState = WIN;
                end else if (w_anyHit) begin
                    w_nextState = DEATH;
                    w_nextLives = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
                    w_nextTimer = 8'(DEATH_FRAMES - 1);
                end else if (r_sub == 6'(SEC_FRAMES - 1)) begin
                    w_nextSub     = '0;
                    w_nextCounter = (r_counter == 5'(MODE_PERIOD - 1)) ? 5'd0 : r_counter + 5'd1;
                end else begin
                    w_nextSub = r_sub + 6'd1;
                end
            end
            DEATH: begin
                if (r_timer != 8'd0) begin
                    w_nextTimer = r_timer - 8'd1;
                end else if (r_lives == 2'd0) begin
                    w_nextState = OVER;
                end else begin
                    w_nextState   = READY;
                    w_nextCounter = '0;
                    w_nextRespawn = 1'b1;
                    w_nextTimer   = 8'(READY_FRAMES - 1);
                end
            end
            OVER, WIN: begin
                if (w_startEdge) begin
                    w_nextState   = READY;
                    w_nextLives   = 2'(LIVES_INIT);
                    w_nextCounter = '0;
                    w_nextRespawn = 1'b1;
                    w_nextTimer   = 8'(READY_FRAMES - 1);
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Status flags decode straight from the registered state, so they stay exclusive.
    always_comb begin
        bus.start_game = (r_state == PLAY);
        bus.game_over  = (r_state == OVER);
        bus.win        = (r_state == WIN);
        bus.counter    = r_counter;
        bus.lives      = r_lives;
        bus.respawn    = r_respawn;
        bus.state      = r_state;
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: start/ready timing, phase counter wrap, deaths,
// game over, win priority, hit-distance boundary and asynchronous reset.
module tb_game_ctrl;
    import game_ctrl_pkg::*;

    logic       frameClk = 1'b0;
    logic       reset;
    int         checks   = 0;
    int         failures = 0;

    logic       startBtn;
    logic [9:0] pacX;
    logic [9:0] pacY;
    logic [9:0] ghostX [4];
    logic [9:0] ghostY [4];
    logic [7:0] dotsLeft;

    game_ctrl_if #(.NUM_GHOSTS(4)) gameBus ();

    game_ctrl #(.NUM_GHOSTS(4)) dut (
        .frame_clk (frameClk),
        .Reset     (reset),
        .bus       (gameBus.slave)
    );

    always #5 frameClk = ~frameClk;

    task automatic applyStimulus();
        gameBus.start_btn = startBtn;
        gameBus.pac_x     = pacX;
        gameBus.pac_y     = pacY;
        gameBus.dots_left = dotsLeft;
        for (int g = 0; g < 4; g++) begin
            gameBus.ghost_x[10*g +: 10] = ghostX[g];
            gameBus.ghost_y[10*g +: 10] = ghostY[g];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    initial begin
        reset    = 1'b1;
        startBtn = 1'b0;
        pacX     = 10'd100;
        pacY     = 10'd100;
        dotsLeft = 8'd50;
        ghostX[0] = 10'd300; ghostY[0] = 10'd50;
        ghostX[1] = 10'd400; ghostY[1] = 10'd60;
        ghostX[2] = 10'd500; ghostY[2] = 10'd70;
        ghostX[3] = 10'd600; ghostY[3] = 10'd80;
        applyStimulus();
        repeat (2) @(negedge frameClk);
        checkOutput("rst_state", gameBus.state, IDLE);
        checkOutput("rst_start_game", gameBus.start_game, 0);
        checkOutput("rst_game_over", gameBus.game_over, 0);
        checkOutput("rst_win", gameBus.win, 0);
        checkOutput("rst_counter", gameBus.counter, 0);
        checkOutput("rst_lives", gameBus.lives, 3);
        checkOutput("rst_respawn", gameBus.respawn, 0);
        reset = 1'b0;
        @(negedge frameClk);

        // Start: respawn pulse now, play exactly 120 frames after.
        startBtn = 1'b1; applyStimulus();
        @(negedge frameClk);
        checkOutput("t1_respawn_hi", gameBus.respawn, 1);
        checkOutput("t1_state_ready", gameBus.state, READY);
        startBtn = 1'b0; applyStimulus();
        @(negedge frameClk);
        checkOutput("t1_respawn_lo", gameBus.respawn, 0);
        repeat (118) @(negedge frameClk);
        checkOutput("t1_not_yet_play", gameBus.start_game, 0);
        @(negedge frameClk);
        checkOutput("t1_start_game", gameBus.start_game, 1);
        checkOutput("t1_state_play", gameBus.state, PLAY);

        // Phase counter: one tick per 60 play frames, wrap after 19.
        repeat (419) @(negedge frameClk);
        checkOutput("t2_counter_419", gameBus.counter, 6);
        @(negedge frameClk);
        checkOutput("t2_counter_420", gameBus.counter, 7);
        repeat (779) @(negedge frameClk);
        checkOutput("t2_counter_1199", gameBus.counter, 19);
        @(negedge frameClk);
        checkOutput("t2_counter_wrap", gameBus.counter, 0);
        repeat (120) @(negedge frameClk);
        checkOutput("t2_counter_1320", gameBus.counter, 2);

        // Ghost 2 at (+5,+11) hits; counter frozen through death.
        ghostX[2] = 10'd105; ghostY[2] = 10'd111; applyStimulus();
        @(negedge frameClk);
        checkOutput("t3_state_death", gameBus.state, DEATH);
        checkOutput("t3_lives", gameBus.lives, 2);
        checkOutput("t3_start_game", gameBus.start_game, 0);
        checkOutput("t3_counter_frozen", gameBus.counter, 2);
        repeat (89) @(negedge frameClk);
        checkOutput("t3_still_death", gameBus.state, DEATH);
        checkOutput("t3_counter_held", gameBus.counter, 2);
        checkOutput("t3_no_respawn", gameBus.respawn, 0);
        @(negedge frameClk);
        checkOutput("t3_state_ready", gameBus.state, READY);
        checkOutput("t3_respawn", gameBus.respawn, 1);
        checkOutput("t3_counter_clr", gameBus.counter, 0);
        @(negedge frameClk);
        checkOutput("t3_respawn_once", gameBus.respawn, 0);

        // Ghost stays put: two more deaths end the game.
        repeat (120) @(negedge frameClk);
        checkOutput("t4_death2", gameBus.state, DEATH);
        checkOutput("t4_lives1", gameBus.lives, 1);
        repeat (90) @(negedge frameClk);
        checkOutput("t4_ready2", gameBus.state, READY);
        repeat (121) @(negedge frameClk);
        checkOutput("t4_death3", gameBus.state, DEATH);
        checkOutput("t4_lives0", gameBus.lives, 0);
        startBtn = 1'b1; applyStimulus();
        repeat (90) @(negedge frameClk);
        checkOutput("t4_game_over", gameBus.game_over, 1);
        checkOutput("t4_over_lives", gameBus.lives, 0);
        checkOutput("t4_over_start_game", gameBus.start_game, 0);
        repeat (5) @(negedge frameClk);
        checkOutput("t4_held_btn", gameBus.state, OVER);
        startBtn = 1'b0; applyStimulus();
        @(negedge frameClk);
        startBtn = 1'b1; applyStimulus();
        @(negedge frameClk);
        checkOutput("t4_restart_state", gameBus.state, READY);
        checkOutput("t4_restart_lives", gameBus.lives, 3);
        checkOutput("t4_restart_over", gameBus.game_over, 0);
        checkOutput("t4_restart_respawn", gameBus.respawn, 1);
        startBtn = 1'b0; applyStimulus();

        // Last dot eaten on the same frame as a hit: win, lives kept.
        repeat (120) @(negedge frameClk);
        checkOutput("t5_play", gameBus.state, PLAY);
        dotsLeft = 8'd0; applyStimulus();
        @(negedge frameClk);
        checkOutput("t5_win", gameBus.win, 1);
        checkOutput("t5_win_state", gameBus.state, WIN);
        checkOutput("t5_win_lives", gameBus.lives, 3);
        checkOutput("t5_win_start_game", gameBus.start_game, 0);

        // dx of exactly 12 is clear; dx of 11 (ghost left of pacman) is a hit.
        startBtn = 1'b1; dotsLeft = 8'd50;
        ghostX[2] = 10'd112; ghostY[2] = 10'd100; applyStimulus();
        @(negedge frameClk);
        checkOutput("t5_win_restart", gameBus.state, READY);
        checkOutput("t5_win_cleared", gameBus.win, 0);
        startBtn = 1'b0; applyStimulus();
        repeat (120) @(negedge frameClk);
        checkOutput("t5_play2", gameBus.state, PLAY);
        repeat (3) @(negedge frameClk);
        checkOutput("t5_dx12_state", gameBus.state, PLAY);
        checkOutput("t5_dx12_lives", gameBus.lives, 3);
        ghostX[0] = 10'd89; ghostY[0] = 10'd100; applyStimulus();
        @(negedge frameClk);
        checkOutput("t5_dx11_hit", gameBus.state, DEATH);
        checkOutput("t5_dx11_lives", gameBus.lives, 2);

        // Reset mid-death with 40 frames left on the timer.
        repeat (49) @(negedge frameClk);
        checkOutput("t6_pre_reset", gameBus.state, DEATH);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_state", gameBus.state, IDLE);
        checkOutput("t6_lives", gameBus.lives, 3);
        checkOutput("t6_start_game", gameBus.start_game, 0);
        checkOutput("t6_counter", gameBus.counter, 0);
        checkOutput("t6_respawn", gameBus.respawn, 0);
        checkOutput("t6_game_over", gameBus.game_over, 0);
        checkOutput("t6_win", gameBus.win, 0);
        @(negedge frameClk);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
